trigger_sequencer: RTL

TRIGGER_SEQUENCER -- requirements
Module: trigger_sequencer

---
 rtl/trigger_sequencer_if.sv | 35 +++
 rtl/trigger_sequencer.sv | 129 ++++++++++++
 2 files changed

// File: rtl/trigger_sequencer_if.sv
// rtl/trigger_sequencer_if.sv - control, mask/count and status bundle of the trigger sequencer
interface trigger_sequencer_if #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4,
  parameter int CNT_W  = 16,
  parameter int SW     = (STAGES > 1) ? $clog2(STAGES) : 1
);
  logic                      in_arm;
  logic                      in_abort;
  logic                      in_valid;
  logic [WIDTH-1:0]          in_data;
  logic [STAGES*WIDTH-1:0]   in_mask_dc;
  logic [STAGES*WIDTH-1:0]   in_mask_rise;
  logic [STAGES*WIDTH-1:0]   in_mask_fall;
  logic [STAGES*WIDTH-1:0]   in_mask_low;
  logic [STAGES*WIDTH-1:0]   in_mask_high;
  logic [STAGES*CNT_W-1:0]   in_count;
  logic                      out_armed;
  logic [SW-1:0]             out_stage;
  logic                      out_trig;
  logic                      out_triggered;
  logic [CNT_W-1:0]          out_trig_pos;

  modport slave (
    input  in_arm, in_abort, in_valid, in_data,
    input  in_mask_dc, in_mask_rise, in_mask_fall, in_mask_low, in_mask_high, in_count,
    output out_armed, out_stage, out_trig, out_triggered, out_trig_pos
  );

  modport master (
    output in_arm, in_abort, in_valid, in_data,
    output in_mask_dc, in_mask_rise, in_mask_fall, in_mask_low, in_mask_high, in_count,
    input  out_armed, out_stage, out_trig, out_triggered, out_trig_pos
  );
endinterface

// File: rtl/trigger_sequencer.sv
// rtl/trigger_sequencer.sv - multi-stage edge/level trigger sequencer with occurrence counts
module trigger_sequencer #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4,
  parameter int CNT_W  = 16,
  parameter int SW     = (STAGES > 1) ? $clog2(STAGES) : 1
) (
  input  logic in_clk,
  input  logic in_rst,
  trigger_sequencer_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_PRIME, ST_RUN, ST_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [SW-1:0]    stage_q, stage_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] scnt_q, scnt_d;
  logic [CNT_W-1:0] pos_q, pos_d;
  logic             trig_q, trig_d;

  logic [WIDTH-1:0] m_dc, m_rise, m_fall, m_low, m_high, cond;
  logic [CNT_W-1:0] cnt_raw, need, scnt_inc, occ_inc;
  logic             hit, satisfied, last_stage;

  // Only the stage currently being searched is ever evaluated.
  assign m_dc    = bus.in_mask_dc  [int'(stage_q)*WIDTH +: WIDTH];
  assign m_rise  = bus.in_mask_rise[int'(stage_q)*WIDTH +: WIDTH];
  assign m_fall  = bus.in_mask_fall[int'(stage_q)*WIDTH +: WIDTH];
  assign m_low   = bus.in_mask_low [int'(stage_q)*WIDTH +: WIDTH];
  assign m_high  = bus.in_mask_high[int'(stage_q)*WIDTH +: WIDTH];
  assign cnt_raw = bus.in_count    [int'(stage_q)*CNT_W +: CNT_W];

  assign cond = m_dc
              | (m_rise & ~prev_q & bus.in_data)
              | (m_fall & prev_q & ~bus.in_data)
              | (m_low & ~bus.in_data)
              | (m_high & bus.in_data);
  assign hit  = &cond;

  assign need       = (cnt_raw == '0) ? CNT_W'(1) : cnt_raw;
  assign satisfied  = hit && (({1'b0, occ_q} + (CNT_W+1)'(1)) >= {1'b0, need});
  assign last_stage = (stage_q == SW'(STAGES - 1));
  assign scnt_inc   = (&scnt_q) ? scnt_q : scnt_q + CNT_W'(1);
  assign occ_inc    = (&occ_q) ? occ_q : occ_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    stage_d = stage_q;
    occ_d   = occ_q;
    scnt_d  = scnt_q;
    pos_d   = pos_q;
    trig_d  = 1'b0;
    if (bus.in_abort) begin
      state_d = ST_IDLE;
      prev_d  = '0;
      stage_d = '0;
      occ_d   = '0;
      scnt_d  = '0;
      pos_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_arm) begin
            state_d = ST_PRIME;
            stage_d = '0;
            occ_d   = '0;
            scnt_d  = '0;
          end
        end
        ST_PRIME: begin
          // First sample only establishes the edge reference.
          if (bus.in_valid) begin
            prev_d  = bus.in_data;
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.in_valid) begin
            prev_d = bus.in_data;
            scnt_d = scnt_inc;
            if (satisfied) begin
              if (last_stage) begin
                state_d = ST_DONE;
                trig_d  = 1'b1;
                pos_d   = scnt_inc;
              end else begin
                stage_d = stage_q + SW'(1);
                occ_d   = '0;
              end
            end else if (hit) begin
              occ_d = occ_inc;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q <= ST_IDLE;
      prev_q  <= '0;
      stage_q <= '0;
      occ_q   <= '0;
      scnt_q  <= '0;
      pos_q   <= '0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      stage_q <= stage_d;
      occ_q   <= occ_d;
      scnt_q  <= scnt_d;
      pos_q   <= pos_d;
      trig_q  <= trig_d;
    end
  end

  assign bus.out_armed     = (state_q == ST_PRIME) || (state_q == ST_RUN);
  assign bus.out_triggered = (state_q == ST_DONE);
  assign bus.out_stage     = stage_q;
  assign bus.out_trig      = trig_q;
  assign bus.out_trig_pos  = pos_q;

endmodule
